// File: rtl/agc_pipa_pkg.sv
// Shared definitions for the PIPA pulse generator: fault codes, axis states
// and the clamped add used by the per-axis pending accumulators.
package agc_pipa_pkg;

  localparam int W_DEF = 8;

  localparam logic [1:0] FLT_NONE = 2'b00;
  localparam logic [1:0] FLT_BOTH = 2'b01;
  localparam logic [1:0] FLT_SUPP = 2'b10;

  typedef enum logic {
    AX_QUIET = 1'b0,
    AX_PULSE = 1'b1
  } axis_state_e;

  // Symmetric clamp to +/-lim; the most negative code is never produced.
  function automatic int sat_add(input int a, input int b, input int lim);
    int s;
    s = a + b;
    if (s > lim) s = lim;
    else if (s < -lim) s = -lim;
    return s;
  endfunction

endpackage

// File: rtl/pipa_axis_gen.sv
// One PIPA axis: signed pending count, pulse timer, idle rebalance phase and
// the fault overlay on the two pulse lines.
module pipa_axis_gen
  import agc_pipa_pkg::*;
#(
  parameter int W         = W_DEF,
  parameter int PULSE_LEN = 4,
  parameter int IDLE_ALT  = 1
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic                load,
  input  logic signed [W-1:0] delta,
  input  logic                tick,
  input  logic [1:0]          fault,
  output logic                pulse_p,
  output logic                pulse_m,
  output logic                idle,
  output logic                satf,
  output logic                ovrn,
  output axis_state_e         state_dbg
);

  localparam int         LIM  = (1 << (W - 1)) - 1;
  localparam logic [3:0] PL_V = 4'(PULSE_LEN);

  axis_state_e        state_q, state_d;
  logic [3:0]         timer_q, timer_d;
  logic signed [W-1:0] pend_q, pend_d;
  logic               phase_q, phase_d;
  logic               line_q, line_d;
  logic               alt_q, alt_d;
  logic               satf_q, satf_d;
  logic               ovrn_q, ovrn_d;

  int step;
  int add;
  int sum;
  int sat;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    phase_d = phase_q;
    line_d  = line_q;
    alt_d   = alt_q;
    satf_d  = satf_q;
    ovrn_d  = ovrn_q;
    step    = 0;
    case (state_q)
      AX_QUIET: begin
        if (tick) begin
          if (int'(pend_q) > 0) begin
            state_d = AX_PULSE; line_d = 1'b0; alt_d = 1'b0; step = 1; timer_d = PL_V;
          end else if (int'(pend_q) < 0) begin
            state_d = AX_PULSE; line_d = 1'b1; alt_d = 1'b0; step = -1; timer_d = PL_V;
          end else if (IDLE_ALT != 0) begin
            state_d = AX_PULSE; line_d = phase_q; phase_d = ~phase_q; alt_d = 1'b1;
            timer_d = PL_V;
          end
        end
      end
      AX_PULSE: begin
        // A tick landing on a live pulse is lost; the count is left alone.
        if (tick) ovrn_d = 1'b1;
        timer_d = timer_q - 4'd1;
        if (timer_q == 4'd1) state_d = AX_QUIET;
      end
      default: state_d = AX_QUIET;
    endcase

    // Tick step is taken before the load so a same-cycle load sees the drained count.
    add = 0;
    if (load) add = (int'(delta) < -LIM) ? -LIM : int'(delta);
    sum = int'(pend_q) - step + add;
    sat = sat_add(int'(pend_q) - step, add, LIM);
    if (sat != sum) satf_d = 1'b1;
    pend_d = W'(sat);
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q <= AX_QUIET;
      timer_q <= '0;
      pend_q  <= '0;
      phase_q <= 1'b0;
      line_q  <= 1'b0;
      alt_q   <= 1'b0;
      satf_q  <= 1'b0;
      ovrn_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      phase_q <= phase_d;
      line_q  <= line_d;
      alt_q   <= alt_d;
      satf_q  <= satf_d;
      ovrn_q  <= ovrn_d;
    end
  end

  logic raw_p;
  logic raw_m;

  always_comb begin
    raw_p = (state_q == AX_PULSE) && !line_q;
    raw_m = (state_q == AX_PULSE) && line_q;
    case (fault)
      FLT_BOTH: begin pulse_p = raw_p | raw_m; pulse_m = raw_p | raw_m; end
      FLT_SUPP: begin pulse_p = 1'b0;          pulse_m = 1'b0;          end
      FLT_NONE: begin pulse_p = raw_p;         pulse_m = raw_m;         end
      default:  begin pulse_p = raw_p;         pulse_m = raw_m;         end
    endcase
  end

  // Rebalance pulses are not real work, so they leave the axis idle.
  assign idle      = (pend_q == '0) && !((state_q == AX_PULSE) && !alt_q);
  assign satf      = satf_q;
  assign ovrn      = ovrn_q;
  assign state_dbg = state_q;

endmodule

// File: rtl/pipa_pulse_gen.sv
// Three-axis PIPA pulse source. LOAD and TICK are single-cycle strobes with no
// backpressure: LOAD adds DX/DY/DZ in the cycle it is high, TICK offers each axis one pulse slot.
module pipa_pulse_gen
  import agc_pipa_pkg::*;
#(
  parameter int W         = W_DEF,
  parameter int PULSE_LEN = 4,
  parameter int IDLE_ALT  = 1
) (
  input  logic                CLOCK,
  input  logic                rst_,
  input  logic                LOAD,
  input  logic signed [W-1:0] DX,
  input  logic signed [W-1:0] DY,
  input  logic signed [W-1:0] DZ,
  input  logic                TICK,
  input  logic [5:0]          FAULT,
  output logic                PIPGXp,
  output logic                PIPGXm,
  output logic                PIPGYp,
  output logic                PIPGYm,
  output logic                PIPGZp,
  output logic                PIPGZm,
  output logic                IDLE,
  output logic                SATF,
  output logic                OVRN,
  output logic [2:0]          DBG_STATE
);

  logic [2:0]  idle_v;
  logic [2:0]  satf_v;
  logic [2:0]  ovrn_v;
  axis_state_e st_x, st_y, st_z;

  pipa_axis_gen #(.W(W), .PULSE_LEN(PULSE_LEN), .IDLE_ALT(IDLE_ALT)) u_axis_x (
    .clk(CLOCK), .rst_(rst_), .load(LOAD), .delta(DX), .tick(TICK), .fault(FAULT[1:0]),
    .pulse_p(PIPGXp), .pulse_m(PIPGXm), .idle(idle_v[0]), .satf(satf_v[0]),
    .ovrn(ovrn_v[0]), .state_dbg(st_x)
  );

  pipa_axis_gen #(.W(W), .PULSE_LEN(PULSE_LEN), .IDLE_ALT(IDLE_ALT)) u_axis_y (
    .clk(CLOCK), .rst_(rst_), .load(LOAD), .delta(DY), .tick(TICK), .fault(FAULT[3:2]),
    .pulse_p(PIPGYp), .pulse_m(PIPGYm), .idle(idle_v[1]), .satf(satf_v[1]),
    .ovrn(ovrn_v[1]), .state_dbg(st_y)
  );

  pipa_axis_gen #(.W(W), .PULSE_LEN(PULSE_LEN), .IDLE_ALT(IDLE_ALT)) u_axis_z (
    .clk(CLOCK), .rst_(rst_), .load(LOAD), .delta(DZ), .tick(TICK), .fault(FAULT[5:4]),
    .pulse_p(PIPGZp), .pulse_m(PIPGZm), .idle(idle_v[2]), .satf(satf_v[2]),
    .ovrn(ovrn_v[2]), .state_dbg(st_z)
  );

  assign IDLE      = &idle_v;
  assign SATF      = |satf_v;
  assign OVRN      = |ovrn_v;
  assign DBG_STATE = {st_z == AX_PULSE, st_y == AX_PULSE, st_x == AX_PULSE};

endmodule

// File: tb/tb_pipa_pulse_gen.sv
// Bench for pipa_pulse_gen: two instances (rebalance off / on) share stimulus;
// a count-level model predicts each pulse, a negedge monitor pops and compares.
module tb_pipa_pulse_gen;

  localparam int W   = 8;
  localparam int PL  = 4;
  localparam int LIM = 127;

  // clock / reset
  logic clk = 1'b0;
  initial forever #5 clk = ~clk;

  logic                rst_  = 1'b0;
  logic                load  = 1'b0;
  logic                tick  = 1'b0;
  logic signed [W-1:0] dx    = '0;
  logic signed [W-1:0] dy    = '0;
  logic signed [W-1:0] dz    = '0;
  logic [5:0]          fault = '0;

  logic [1:0][5:0] pg;
  logic [1:0]      idle;
  logic [1:0]      satf;
  logic [1:0]      ovrn;
  logic [1:0][2:0] dbg;

  pipa_pulse_gen #(.W(W), .PULSE_LEN(PL), .IDLE_ALT(0)) u_dut_q (
    .CLOCK(clk), .rst_(rst_), .LOAD(load), .DX(dx), .DY(dy), .DZ(dz), .TICK(tick),
    .FAULT(fault), .PIPGXp(pg[0][0]), .PIPGXm(pg[0][1]), .PIPGYp(pg[0][2]),
    .PIPGYm(pg[0][3]), .PIPGZp(pg[0][4]), .PIPGZm(pg[0][5]), .IDLE(idle[0]),
    .SATF(satf[0]), .OVRN(ovrn[0]), .DBG_STATE(dbg[0])
  );

  pipa_pulse_gen #(.W(W), .PULSE_LEN(PL), .IDLE_ALT(1)) u_dut_a (
    .CLOCK(clk), .rst_(rst_), .LOAD(load), .DX(dx), .DY(dy), .DZ(dz), .TICK(tick),
    .FAULT(fault), .PIPGXp(pg[1][0]), .PIPGXm(pg[1][1]), .PIPGYp(pg[1][2]),
    .PIPGYm(pg[1][3]), .PIPGZp(pg[1][4]), .PIPGZm(pg[1][5]), .IDLE(idle[1]),
    .SATF(satf[1]), .OVRN(ovrn[1]), .DBG_STATE(dbg[1])
  );

  // reference model state ([dut][axis]); dut 1 has rebalance pulses enabled
  int        cyc = 0;
  bit        rst_taken = 1'b1;
  int        pend[2][3];
  int        busy_end[2][3];
  int        real_end[2][3];
  bit        phase[2][3];
  bit        m_satf[2];
  bit        m_ovrn[2];
  logic [31:0] exp_q[6][$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // One clock edge of the model; called right at the edge with the sampled inputs.
  task automatic model_step();
    int c, d, step, line, v, idx;
    bit [1:0] f, pat;
    c = cyc;
    rst_taken = !rst_;
    for (int k = 0; k < 2; k++) begin
      if (!rst_) begin
        m_satf[k] = 1'b0;
        m_ovrn[k] = 1'b0;
      end
      for (int a = 0; a < 3; a++) begin
        idx = k * 3 + a;
        if (!rst_) begin
          pend[k][a] = 0; busy_end[k][a] = 0; real_end[k][a] = 0; phase[k][a] = 1'b0;
          exp_q[idx].delete();
        end else begin
          d = (a == 0) ? int'(dx) : (a == 1) ? int'(dy) : int'(dz);
          if (d < -LIM) d = -LIM;
          step = 0;
          line = -1;
          if (tick) begin
            if (c < busy_end[k][a]) m_ovrn[k] = 1'b1;
            else begin
              if (pend[k][a] > 0) begin line = 0; step = 1; end
              else if (pend[k][a] < 0) begin line = 1; step = -1; end
              else if (k == 1) begin line = int'(phase[k][a]); phase[k][a] = ~phase[k][a]; end
              if (line >= 0) begin
                busy_end[k][a] = c + 1 + PL;
                if (step != 0) real_end[k][a] = c + 1 + PL;
                f = fault[2*a +: 2];
                if (f != 2'b10) begin
                  pat = (f == 2'b01) ? 2'b11 : ((line == 0) ? 2'b10 : 2'b01);
                  exp_q[idx].push_back(32'((c + 1) * 4 + int'(pat)));
                end
              end
            end
          end
          v = pend[k][a] - step + (load ? d : 0);
          if (v > LIM) begin v = LIM; m_satf[k] = 1'b1; end
          else if (v < -LIM) begin v = -LIM; m_satf[k] = 1'b1; end
          pend[k][a] = v;
        end
      end
    end
    cyc = c + 1;
  endtask

  // driver tasks
  task automatic cyc_drive(input bit t, input bit l, input int x, input int y, input int z);
    tick = t;
    load = l;
    dx = 8'(x);
    dy = 8'(y);
    dz = 8'(z);
    @(posedge clk);
    model_step();
    #1;
    tick = 1'b0;
    load = 1'b0;
  endtask

  task automatic tick_run(input int n, input int period, input logic [5:0] f);
    for (int i = 0; i < n; i++) begin
      repeat (period - 1) cyc_drive(1'b0, 1'b0, 0, 0, 0);
      fault = f;
      cyc_drive(1'b1, 1'b0, 0, 0, 0);
    end
  endtask

  function automatic int rnd_delta();
    int r;
    r = int'($urandom_range(0, 31));
    if (r == 0) return -128;
    if (r == 1) return 127;
    return int'($urandom_range(0, 40)) - 20;
  endfunction

  // monitor / scoreboard
  bit       in_run[6];
  int       run_len[6];
  bit [1:0] run_pat[6];

  initial begin
    bit       exp_idle;
    bit [1:0] cur;
    int       idx;
    int       got;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rst_taken) begin
          chk("reset_pulses", int'(pg[k]), 0);
          chk("reset_idle", int'(idle[k]), 1);
          chk("reset_satf", int'(satf[k]), 0);
          chk("reset_ovrn", int'(ovrn[k]), 0);
          for (int a = 0; a < 3; a++) in_run[k*3+a] = 1'b0;
        end else begin
          exp_idle = 1'b1;
          for (int a = 0; a < 3; a++) begin
            idx = k * 3 + a;
            if (pend[k][a] != 0 || cyc < real_end[k][a]) exp_idle = 1'b0;
            chk("axis_busy", int'(dbg[k][a]), (cyc < busy_end[k][a]) ? 1 : 0);
            cur = {pg[k][2*a], pg[k][2*a+1]};
            if (!in_run[idx]) begin
              if (cur != 2'b00) begin
                in_run[idx] = 1'b1;
                run_len[idx] = 1;
                run_pat[idx] = cur;
                got = (exp_q[idx].size() == 0) ? -1 : int'(exp_q[idx].pop_front());
                chk("pulse_start_and_lines", cyc * 4 + int'(cur), got);
              end
            end else if (cur != 2'b00) begin
              run_len[idx]++;
              chk("pulse_lines_steady", int'(cur), int'(run_pat[idx]));
            end else begin
              in_run[idx] = 1'b0;
              chk("pulse_length", run_len[idx], PL);
            end
          end
          chk("idle", int'(idle[k]), int'(exp_idle));
          chk("satf", int'(satf[k]), int'(m_satf[k]));
          chk("ovrn", int'(ovrn[k]), int'(m_ovrn[k]));
        end
      end
    end
  end

  // stimulus and final report
  initial begin
    int per;
    bit ld;
    repeat (3) cyc_drive(1'b0, 1'b0, 0, 0, 0);
    rst_ = 1'b1;

    // +3 on X drains as three p pulses
    cyc_drive(1'b0, 1'b1, 3, 0, 0);
    tick_run(10, 16, 6'b000000);

    // -2 on Y and +1 on Z share ticks
    cyc_drive(1'b0, 1'b1, 0, -2, 1);
    tick_run(4, 16, 6'b000000);

    // no load: only the rebalancing instance pulses
    tick_run(4, 16, 6'b000000);

    // two loads of +100 clamp at +127
    cyc_drive(1'b0, 1'b1, 100, 0, 0);
    cyc_drive(1'b0, 1'b1, 100, 0, 0);
    tick_run(130, 6, 6'b000000);

    // fault overlays on X while draining
    cyc_drive(1'b0, 1'b1, 2, 0, 0);
    tick_run(3, 16, 6'b000001);
    cyc_drive(1'b0, 1'b1, 2, 0, 0);
    tick_run(3, 16, 6'b000010);
    tick_run(1, 16, 6'b000000);

    // ticks faster than the pulse length
    cyc_drive(1'b0, 1'b1, 5, -5, 5);
    tick_run(6, 3, 6'b000000);

    // reset in the middle of a pulse
    cyc_drive(1'b0, 1'b1, 4, 0, 0);
    repeat (3) cyc_drive(1'b0, 1'b0, 0, 0, 0);
    cyc_drive(1'b1, 1'b0, 0, 0, 0);
    cyc_drive(1'b0, 1'b0, 0, 0, 0);
    rst_ = 1'b0;
    cyc_drive(1'b0, 1'b0, 0, 0, 0);
    rst_ = 1'b1;
    repeat (2) cyc_drive(1'b0, 1'b0, 0, 0, 0);

    // randomized loads, tick periods and faults
    for (int it = 0; it < 80; it++) begin
      per = int'($urandom_range(5, 12));
      for (int j = 0; j < per; j++) begin
        ld = ($urandom_range(0, 3) == 0);
        if (j == per - 1) fault = 6'($urandom_range(0, 63));
        cyc_drive(j == per - 1, ld, rnd_delta(), rnd_delta(), rnd_delta());
      end
    end

    repeat (2 * PL + 4) cyc_drive(1'b0, 1'b0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      chk("leftover_expected_pulses", exp_q[i].size(), 0);
      chk("pulse_still_open", int'(in_run[i]), 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
